// File: rtl/systolic_act_feeder.sv
// Activation feeder for a weight-stationary systolic array.
// Skews vector lanes per row and drives the array-wide enable.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, num_vecs   pass command, vector count latched on accept
//   in_valid/in_ready/in_data  activation vector handshake
//   arr_enable        array-global pipeline enable
//   act_row/act_row_vld  skewed left-edge lanes and real-element flags
//   busy, done        pass in progress, end-of-pass pulse
module systolic_act_feeder #(
  parameter int ARRAY_ROWS   = 4,
  parameter int ARRAY_COLS   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int SKEW_PER_ROW = 2,
  parameter int CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 num_vecs,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_ROWS*DATA_WIDTH-1:0] in_data,
  output logic                             arr_enable,
  output logic [ARRAY_ROWS*DATA_WIDTH-1:0] act_row,
  output logic [ARRAY_ROWS-1:0]            act_row_vld,
  output logic                             busy,
  output logic                             done
);

  localparam int DW = DATA_WIDTH;
  localparam int DRAIN_LEN =
    (ARRAY_ROWS - 1) * SKEW_PER_ROW + 2 * ARRAY_COLS;
  localparam int DRN_W =
    (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             last_vec;

  assign last_vec = vec_cnt_q == num_q - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      num_q     <= '0;
      drn_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      num_q     <= num_d;
      drn_q     <= drn_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_cnt_d  = vec_cnt_q;
    num_d      = num_q;
    drn_d      = drn_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    arr_enable = 1'b0;
    xfer       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vecs == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = STREAM;
            vec_cnt_d = '0;
            num_d     = num_vecs;
          end
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        // A bubble freezes the whole array rather
        // than injecting a zero element.
        xfer       = in_valid;
        arr_enable = in_valid;
        if (in_valid) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (last_vec) begin
            if (DRAIN_LEN == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              drn_d   = DRN_W'(DRAIN_LEN - 1);
            end
          end
        end
      end
      DRAIN: begin
        arr_enable = 1'b1;
        if (drn_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = state_q != IDLE;
  assign done = done_q;

  // Lane 0 feeds PE(0,0) directly; deeper rows
  // see the same gated value after r*SKEW enables.
  assign act_row[DW-1:0] = xfer ? in_data[DW-1:0] : '0;
  assign act_row_vld[0]  = xfer;

  for (genvar r = 1; r < ARRAY_ROWS; r++) begin : g_lane
    localparam int DEP = r * SKEW_PER_ROW;
    logic [DW-1:0] lane_in;
    assign lane_in = xfer ? in_data[r*DW +: DW] : '0;

    if (DEP == 0) begin : g_thru
      assign act_row[r*DW +: DW] = lane_in;
      assign act_row_vld[r]      = xfer;
    end else begin : g_sr
      logic [DW-1:0]  dq [DEP];
      logic [DEP-1:0] vq;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEP; i++) dq[i] <= '0;
          vq <= '0;
        end else if (arr_enable) begin
          dq[0] <= lane_in;
          vq[0] <= xfer;
          for (int i = 1; i < DEP; i++) begin
            dq[i] <= dq[i-1];
            vq[i] <= vq[i-1];
          end
        end
      end

      assign act_row[r*DW +: DW] = dq[DEP-1];
      assign act_row_vld[r]      = vq[DEP-1];
    end
  end

endmodule

// File: tb/tb_systolic_act_feeder.sv
// Self-checking bench for systolic_act_feeder.
// Per-cycle comparison against an enable-count model.
module tb_systolic_act_feeder;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 16;
  localparam int D  = (R - 1) * S + 2 * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vecs;
  logic          in_valid;
  logic          in_ready;
  logic [R*W-1:0] in_data;
  logic          arr_enable;
  logic [R*W-1:0] act_row;
  logic [R-1:0]  act_row_vld;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_act_feeder #(
    .ARRAY_ROWS  (R),
    .ARRAY_COLS  (C),
    .DATA_WIDTH  (W),
    .SKEW_PER_ROW(S),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vecs   (num_vecs),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .arr_enable (arr_enable),
    .act_row    (act_row),
    .act_row_vld(act_row_vld),
    .busy       (busy),
    .done       (done)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: a pass is num vectors followed by D flush
  // enables; element r of vector k appears on enable
  // number k + r*S.
  bit             m_act;
  int             m_n;
  int             m_e;
  bit             m_done;
  logic [R*W-1:0] m_vec [0:63];

  task automatic tick();
    logic [R*W-1:0] er;
    logic [R-1:0]   ev;
    bit             xf;
    bit             en;
    bit             was_act;
    int             idx;
    #1;
    was_act = m_act;
    xf = m_act && (m_e < m_n) && in_valid;
    en = m_act && ((m_e < m_n) ? in_valid : 1'b1);
    er = '0;
    ev = '0;
    if (xf) begin
      er[W-1:0] = in_data[W-1:0];
      ev[0]     = 1'b1;
    end
    for (int r = 1; r < R; r++) begin
      idx = m_e - r * S;
      if (idx >= 0 && idx < m_n) begin
        er[r*W +: W] = m_vec[idx][r*W +: W];
        ev[r]        = 1'b1;
      end
    end
    check("arr_enable", 64'(arr_enable), 64'(en));
    check("in_ready", 64'(in_ready),
          64'(m_act && m_e < m_n));
    check("busy", 64'(busy), 64'(m_act));
    check("done", 64'(done), 64'(m_done));
    check("act_row", 64'(act_row), 64'(er));
    check("act_row_vld", 64'(act_row_vld), 64'(ev));
    m_done = 1'b0;
    if (xf) m_vec[m_e] = in_data;
    if (en) begin
      m_e++;
      if (m_e == m_n + D) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end
    if (!was_act && start) begin
      if (num_vecs == '0) begin
        m_done = 1'b1;
      end else begin
        m_act = 1'b1;
        m_n   = int'(num_vecs);
        m_e   = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cmd(int n);
    start    = 1'b1;
    num_vecs = CW'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(logic [R*W-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_out();
    int guard;
    guard = 0;
    while (m_act && guard < 200) begin
      tick();
      guard++;
    end
    check("pass_timeout", 64'(m_act), 64'd0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_enable", 64'(arr_enable), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_row", 64'(act_row), 64'd0);
    check("rst_vld", 64'(act_row_vld), 64'd0);
    m_act  = 1'b0;
    m_n    = 0;
    m_e    = 0;
    m_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [R*W-1:0] v1, v2, v3;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    num_vecs = '0;
    in_valid = 1'b0;
    in_data  = '0;
    m_act    = 1'b0;
    m_n      = 0;
    m_e      = 0;
    m_done   = 1'b0;
    v1 = {8'd4, 8'd3, 8'd2, 8'd1};
    v2 = {8'd8, 8'd7, 8'd6, 8'd5};
    v3 = {8'd12, 8'd11, 8'd10, 8'd9};
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back three-vector pass.
    cmd(3);
    feed(v1);
    feed(v2);
    feed(v3);
    run_out();

    // Two-cycle bubble after the first vector.
    cmd(3);
    feed(v1);
    tick();
    tick();
    feed(v2);
    feed(v3);
    run_out();

    // Zero-length pass.
    cmd(0);
    tick();
    tick();

    // Start mid-stream is ignored.
    cmd(3);
    feed(v1);
    start    = 1'b1;
    num_vecs = CW'(9);
    tick();
    start = 1'b0;
    feed(v2);
    feed(v3);
    run_out();

    // Reset mid-stream, then a single vector.
    cmd(3);
    feed(v1);
    feed(v2);
    do_reset();
    tick();
    cmd(1);
    feed({8'h04, 8'hFD, 8'h02, 8'hFF});
    run_out();

    // Random passes with back-pressure and stray starts.
    for (int p = 0; p < 12; p++) begin
      cmd((p == 5) ? 0 : int'($urandom_range(1, 16)));
      for (int g = 0; g < 200 && m_act; g++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        start    = ($urandom_range(0, 15) == 0);
        num_vecs = CW'($urandom_range(0, 20));
        tick();
      end
      start = 1'b0;
      check("rand_timeout", 64'(m_act), 64'd0);
      for (int i = 0; i < 3; i++) begin
        in_valid = $urandom_range(0, 1) != 0;
        in_data  = $urandom;
        tick();
      end
      in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
